pipe_barrel_shifter: RTL and testbench
======================================

// Module: pipe_barrel_shifter
// PURPOSE
//  Parametrised, pipelined barrel shifter supporting arithmetic, logical and rotate shifts in both directions.
//  Operands of WIDTH bits enter over a valid/ready handshake.
//  Each log2 shift stage is registered; results leave over a second valid/ready handshake.
//  Arithmetic-left overflow and illegal-opcode flags travel with the result.
//  Sits between the ALU operand mux and the writeback arbiter; a user tag rides alongside each operation.
// PARAMETERS
//  WIDTH  8  data width; power of two, 4..64
//  TAGW   4  width of the pass-through tag; minimum 1
//  SHW    $clog2(WIDTH)  localparam: shift-amount width, also the number of pipeline stages
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand valid
//  in_ready   out  1      block can accept an operand this cycle
//  in_a       in   WIDTH  operand
//  in_s       in   SHW    shift amount, 0..WIDTH-1
//  in_op      in   3      000 ASL, 001 LSL, 010 ROL, 100 ASR, 101 LSR, 110 ROR; 011 and 111 are illegal
//  in_tag     in   TAGW   user tag, returned unchanged
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  out_y      out  WIDTH  shifted result
//  out_ovf    out  1      ASL only: signed overflow
//  out_err    out  1      illegal opcode seen
//  out_tag    out  TAGW   tag of this result
// BEHAVIOUR
//  - Reset: every stage valid bit is 0 immediately and asynchronously.
//    out_valid=0, out_y=0, out_ovf=0, out_err=0, out_tag=0.
//    in_ready=1 one cycle after rst_n deasserts.
//  - Pipeline: SHW register stages.
//    Stage k (k=0..SHW-1) shifts by 2^(SHW-1-k) when bit in_s[SHW-1-k] is set, largest shift first.
//    Latency is SHW cycles from input handshake to out_valid with no stall.
//    Throughput is 1 operation per cycle.
//  - Stall: global enable en = !out_valid | out_ready. All stages advance only when en=1.
//    in_ready = en, so a transfer happens when in_valid & in_ready.
//    Bubbles are not compressed.
//    While out_valid=1 and out_ready=0, out_* hold stable.
//  - Fill per operation:
//    - LSL and ASL fill vacated bits with 0.
//    - LSR fills with 0.
//    - ASR fills with the running MSB of the stage input (the sign).
//    - ROL and ROR wrap the bits around.
//  - Overflow (ASL only): sticky across stages. A stage shifting by m sets ovf if the top m+1 bits of
//    its input are not all equal. Result: out_ovf=1 exactly when a*2^s is not representable in WIDTH
//    signed bits. out_ovf=0 for every other opcode.
//  - Illegal opcode: out_y=0, out_ovf=0, out_err=1; the operation still occupies a slot and completes.
//  - s=0 returns in_a unchanged for every legal op, with out_ovf=0.
//  - Op, s-remainder, tag and flags are carried in each stage register with the data.
//  - Reset during operation: all in-flight operations are discarded and none emerges after reset.
// STRUCTURE
//  - Shared package (shifter_pkg):
//    - opcode localparams OP_ASL..OP_ROR
//    - a function op_is_legal
//    - a function op_is_left
//  - One sub-module, shifter_stage: a parametrised AMT shift/rotate/fill mux plus its overflow term,
//    instantiated SHW times by generate.
//  - The top level holds the stage registers, the valid chain and the enable logic.
// TESTING
//  - WIDTH=8, ASL a=0x40 s=1 -> y=0x80 ovf=1; ASL a=0x10 s=2 -> y=0x40 ovf=0;
//    ASL a=0xF0 s=3 -> y=0x80 ovf=0.
//  - ROR a=0x81 s=1 -> y=0xC0; ROL a=0x81 s=4 -> y=0x18; ASR a=0x80 s=3 -> y=0xF0;
//    LSR a=0x80 s=7 -> y=0x01.
//  - Back-to-back: 8 ops on consecutive cycles with out_ready=1.
//    Required: results in order, the first exactly 3 cycles after acceptance, tags matching.
//  - Backpressure: drop out_ready for 5 cycles mid-stream.
//    Required: in_ready=0, out_* stable, no loss or duplication; a scoreboard compares against a model.
//  - op=011, a=0xFF -> y=0x00, err=1, ovf=0. Assert rst_n low with 3 ops in flight:
//    out_valid falls at once and no stale result appears after release.
//  - WIDTH=16, TAGW=2: random sweep of all ops and s=0..15 against a reference model;
//    check ASR of 0x8000 by 15 gives 0xFFFF.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared opcode encodings and opcode helpers for the pipelined barrel shifter
package shifter_pkg;

    localparam logic [2:0] OP_ASL = 3'b000;
    localparam logic [2:0] OP_LSL = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b100;
    localparam logic [2:0] OP_LSR = 3'b101;
    localparam logic [2:0] OP_ROR = 3'b110;

    // 011 and 111 are the only unused encodings
    function automatic logic op_is_legal(input logic [2:0] op);
        return op[1:0] != 2'b11;
    endfunction

    function automatic logic op_is_left(input logic [2:0] op);
        return !op[2];
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// rtl/shifter_stage.sv - one fixed-amount shift/rotate/fill mux with its sticky ASL overflow term
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       op,
    input  logic             apply,
    input  logic             ovf_in,
    output logic [WIDTH-1:0] y,
    output logic             ovf_out
);

    logic [AMT:0]       top;
    logic               lost;
    logic [WIDTH-1:0]   rol;
    logic [WIDTH-1:0]   ror;

    // shifting left by AMT keeps the signed value only if the top AMT+1 bits agree
    assign top  = a[WIDTH-1 -: AMT+1];
    assign lost = (top != '0) && (top != '1);
    assign rol  = (a << AMT) | (a >> (WIDTH - AMT));
    assign ror  = (a >> AMT) | (a << (WIDTH - AMT));

    always_comb begin
        y       = a;
        ovf_out = ovf_in;
        if (apply) begin
            case (op)
                OP_ASL: begin
                    y       = a << AMT;
                    ovf_out = ovf_in | lost;
                end
                OP_LSL:         y = a << AMT;
                OP_ROL, OP_ROR: y = op_is_left(op) ? rol : ror;
                OP_ASR:         y = $signed(a) >>> AMT;
                OP_LSR:         y = a >> AMT;
                default:        y = a;
            endcase
        end
    end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// rtl/pipe_barrel_shifter.sv - log2-stage registered barrel shifter with valid/ready on both sides
module pipe_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int TAGW  = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_s,
    input  logic [2:0]       in_op,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_ovf,
    output logic             out_err,
    output logic [TAGW-1:0]  out_tag
);

    logic                 rdy_q;
    logic                 en;
    logic                 in_fire;
    logic                 e_legal;

    logic                 v_q   [SHW];
    logic [WIDTH-1:0]     d_q   [SHW];
    logic [TAGW-1:0]      tag_q [SHW];
    logic                 ovf_q [SHW];
    logic                 err_q [SHW];
    logic [2:0]           op_q  [SHW-1];
    logic [SHW-1:0]       s_q   [SHW-1];

    // hold off the first transfer until a clock edge has passed since reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    assign en       = !out_valid || out_ready;
    assign in_ready = rdy_q && en;
    assign in_fire  = in_valid && in_ready;
    assign e_legal  = op_is_legal(in_op);

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic             v_i;
        logic [WIDTH-1:0] d_i;
        logic [WIDTH-1:0] d_o;
        logic [2:0]       op_i;
        logic [TAGW-1:0]  tag_i;
        logic             ovf_i;
        logic             ovf_o;
        logic             err_i;
        logic             apply;

        // illegal opcodes enter as zero data so every later stage just passes them through
        if (k == 0) begin : g_first
            assign v_i   = in_fire;
            assign d_i   = e_legal ? in_a : '0;
            assign op_i  = in_op;
            assign tag_i = in_tag;
            assign ovf_i = 1'b0;
            assign err_i = !e_legal;
            assign apply = in_s[SHW-1];
        end else begin : g_next
            assign v_i   = v_q[k-1];
            assign d_i   = d_q[k-1];
            assign op_i  = op_q[k-1];
            assign tag_i = tag_q[k-1];
            assign ovf_i = ovf_q[k-1];
            assign err_i = err_q[k-1];
            assign apply = s_q[k-1][SHW-1-k];
        end

        shifter_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << (SHW-1-k))
        ) u_stage (
            .a       (d_i),
            .op      (op_i),
            .apply   (apply),
            .ovf_in  (ovf_i),
            .y       (d_o),
            .ovf_out (ovf_o)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k]   <= 1'b0;
                d_q[k]   <= '0;
                tag_q[k] <= '0;
                ovf_q[k] <= 1'b0;
                err_q[k] <= 1'b0;
            end else if (en) begin
                v_q[k]   <= v_i;
                d_q[k]   <= d_o;
                tag_q[k] <= tag_i;
                ovf_q[k] <= ovf_o;
                err_q[k] <= err_i;
            end
        end

        // the last stage needs no opcode or shift amount downstream
        if (k < SHW-1) begin : g_carry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    op_q[k] <= '0;
                    s_q[k]  <= '0;
                end else if (en) begin
                    op_q[k] <= op_i;
                    s_q[k]  <= (k == 0) ? in_s : s_q[(k == 0) ? 0 : k-1];
                end
            end
        end
    end

    assign out_valid = v_q[SHW-1];
    assign out_y     = d_q[SHW-1];
    assign out_ovf   = ovf_q[SHW-1];
    assign out_err   = err_q[SHW-1];
    assign out_tag   = tag_q[SHW-1];

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// tb/tb_pipe_barrel_shifter.sv - scoreboard bench for pipe_barrel_shifter at WIDTH=8 and WIDTH=16
module tb_pipe_barrel_shifter;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_ovf, out_err;
    logic [7:0] in_a, out_y;
    logic [2:0] in_s, in_op;
    logic [3:0] in_tag, out_tag;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, out_ovf16, out_err16;
    logic [15:0] in_a16, out_y16;
    logic [3:0]  in_s16;
    logic [2:0]  in_op16;
    logic [1:0]  in_tag16, out_tag16;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_lat = 0;

    typedef struct {
        logic [15:0] y;
        logic        ovf;
        logic        err;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];

    pipe_barrel_shifter #(.WIDTH(8), .TAGW(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_s(in_s), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_ovf(out_ovf), .out_err(out_err), .out_tag(out_tag)
    );

    pipe_barrel_shifter #(.WIDTH(16), .TAGW(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_s(in_s16), .in_op(in_op16), .in_tag(in_tag16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_y(out_y16),
        .out_ovf(out_ovf16), .out_err(out_err16), .out_tag(out_tag16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference built from whole-number arithmetic rather than per-stage muxes
    function automatic void ref_model(input int w, input logic [15:0] a, input int s,
                                      input logic [2:0] op, output logic [15:0] y,
                                      output logic ovf, output logic err);
        longint mask, ua, sa, p, mx, r;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        sa   = ((ua >> (w-1)) & 1) != 0 ? (ua | ~mask) : ua;
        mx   = longint'(1) << (w-1);
        ovf  = 1'b0;
        err  = 1'b0;
        case (op)
            3'b000: begin
                r   = (ua << s) & mask;
                p   = sa * (longint'(1) << s);
                ovf = (p >= mx) || (p < -mx);
            end
            3'b001:  r = (ua << s) & mask;
            3'b010:  r = ((ua << s) | (ua >> (w-s))) & mask;
            3'b100:  r = (sa >>> s) & mask;
            3'b101:  r = ua >> s;
            3'b110:  r = ((ua >> s) | (ua << (w-s))) & mask;
            default: begin r = 0; err = 1'b1; end
        endcase
        y = r[15:0];
    endfunction

    task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [2:0] s,
                         input logic [3:0] tag, input logic [7:0] y, input logic ovf,
                         input logic err);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_s = s; in_op = op; in_tag = tag;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout8", 0, 1);
        else sb8.push_back('{{8'h00, y}, ovf, err, tag, cyc});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send16(input logic [2:0] op, input logic [15:0] a, input logic [3:0] s,
                          input logic [1:0] tag, input logic [15:0] y, input logic ovf,
                          input logic err);
        int n = 0;
        @(negedge clk);
        in_valid16 = 1'b1; in_a16 = a; in_s16 = s; in_op16 = op; in_tag16 = tag;
        while (!in_ready16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready16) chk("in_ready_timeout16", 0, 1);
        else sb16.push_back('{y, ovf, err, {2'b00, tag}, cyc});
        @(posedge clk);
        #1 in_valid16 = 1'b0;
    endtask

    task automatic send8_model(input logic [2:0] op, input logic [7:0] a, input logic [2:0] s,
                               input logic [3:0] tag);
        logic [15:0] y;
        logic ovf, err;
        ref_model(8, {8'h00, a}, int'(s), op, y, ovf, err);
        send8(op, a, s, tag, y[7:0], ovf, err);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb8.size() != 0 || sb16.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain8_left", sb8.size(), 0);
        chk("drain16_left", sb16.size(), 0);
    endtask

    // WIDTH=8 monitor: pops on every accepted result and watches held outputs under backpressure
    initial begin
        exp_t e;
        bit stalled = 0;
        logic [7:0] h_y;
        logic h_ovf, h_err;
        logic [3:0] h_tag;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
                continue;
            end
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_y", out_y, h_y);
                chk("hold_flags", {out_ovf, out_err}, {h_ovf, h_err});
                chk("hold_tag", out_tag, h_tag);
            end
            if (out_valid && out_ready) begin
                if (sb8.size() == 0) begin
                    chk("unexpected_out8", 1, 0);
                end else begin
                    e = sb8.pop_front();
                    chk("y8", out_y, e.y[7:0]);
                    chk("ovf8", out_ovf, e.ovf);
                    chk("err8", out_err, e.err);
                    chk("tag8", out_tag, e.tag);
                    if (chk_lat) chk("latency8", cyc - e.acc, 3);
                end
            end
            stalled = out_valid && !out_ready;
            if (stalled) chk("stall_in_ready", in_ready, 0);
            h_y = out_y; h_ovf = out_ovf; h_err = out_err; h_tag = out_tag;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid16 && out_ready16) begin
                if (sb16.size() == 0) begin
                    chk("unexpected_out16", 1, 0);
                end else begin
                    e = sb16.pop_front();
                    chk("y16", out_y16, e.y);
                    chk("ovf16", out_ovf16, e.ovf);
                    chk("err16", out_err16, e.err);
                    chk("tag16", out_tag16, e.tag[1:0]);
                end
            end
        end
    end

    initial begin
        logic [2:0] legal_ops [6];
        logic [15:0] pats [4];
        logic [15:0] y16;
        logic ovf16, err16;
        int t;
        legal_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
        pats = '{16'h8000, 16'h7FFF, 16'h1234, 16'hC3A5};

        rst_n = 1'b1; in_valid = 0; in_a = 0; in_s = 0; in_op = 0; in_tag = 0; out_ready = 1;
        in_valid16 = 0; in_a16 = 0; in_s16 = 0; in_op16 = 0; in_tag16 = 0; out_ready16 = 1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_tag", out_tag, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_ready_at_release", in_ready, 0);
        @(posedge clk);
        #1 chk("in_ready_after_edge", in_ready, 1);

        // directed vectors issued back to back, latency checked against the acceptance cycle
        chk_lat = 1;
        send8(3'b000, 8'h40, 3'd1, 4'd0, 8'h80, 1'b1, 1'b0);
        send8(3'b000, 8'h10, 3'd2, 4'd1, 8'h40, 1'b0, 1'b0);
        send8(3'b000, 8'hF0, 3'd3, 4'd2, 8'h80, 1'b0, 1'b0);
        send8(3'b110, 8'h81, 3'd1, 4'd3, 8'hC0, 1'b0, 1'b0);
        send8(3'b010, 8'h81, 3'd4, 4'd4, 8'h18, 1'b0, 1'b0);
        send8(3'b100, 8'h80, 3'd3, 4'd5, 8'hF0, 1'b0, 1'b0);
        send8(3'b101, 8'h80, 3'd7, 4'd6, 8'h01, 1'b0, 1'b0);
        send8(3'b011, 8'hFF, 3'd2, 4'd7, 8'h00, 1'b0, 1'b1);
        drain(50);
        chk_lat = 0;

        send8(3'b000, 8'hC0, 3'd0, 4'd8, 8'hC0, 1'b0, 1'b0);
        send8(3'b100, 8'h96, 3'd0, 4'd9, 8'h96, 1'b0, 1'b0);
        send8(3'b111, 8'h5A, 3'd0, 4'd10, 8'h00, 1'b0, 1'b1);
        drain(50);

        fork
            begin
                for (int i = 0; i < 12; i++)
                    send8_model(legal_ops[i % 6], 8'(8'h5A + i * 37), 3'(i % 8), 4'(i));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain(100);

        // reset with three results parked in the pipe
        @(posedge clk);
        #1 out_ready = 1'b0;
        send8(3'b001, 8'h03, 3'd1, 4'd11, 8'h06, 1'b0, 1'b0);
        send8(3'b001, 8'h03, 3'd2, 4'd12, 8'h0C, 1'b0, 1'b0);
        send8(3'b001, 8'h03, 3'd3, 4'd13, 8'h18, 1'b0, 1'b0);
        chk("inflight_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_y", out_y, 0);
        sb8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_stale_valid", out_valid, 0);

        send16(3'b100, 16'h8000, 4'd15, 2'd1, 16'hFFFF, 1'b0, 1'b0);
        t = 0;
        for (int o = 0; o < 8; o++) begin
            for (int s = 0; s < 16; s++) begin
                for (int p = 0; p < 4; p++) begin
                    ref_model(16, pats[p], s, 3'(o), y16, ovf16, err16);
                    send16(3'(o), pats[p], 4'(s), 2'(t), y16, ovf16, err16);
                    t++;
                end
            end
        end
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
